// File: rtl/pulse_stretch.sv
// pulse_stretch: turns single-cycle events into fixed-width output pulses.
// Each pulse is followed by a guaranteed low gap. Events that arrive while a
// pulse is in flight are either merged into it (RETRIGGER=1, HIGH only) or
// counted in a saturating pending counter and replayed back-to-back.
module pulse_stretch #(
    parameter int HIGH_CYCLES = 4,
    parameter int GAP_CYCLES  = 2,
    parameter int RETRIGGER   = 0,
    parameter int MAX_PENDING = 3,
    parameter int CNT_W       = 8,
    parameter int PEND_W      = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in,
    output logic              out,
    output logic              busy,
    output logic [PEND_W-1:0] pending,
    output logic              dropped
);

    typedef enum logic [1:0] {IDLE, HIGH, GAP} state_t;

    localparam logic [CNT_W-1:0]  HIGH_LOAD = CNT_W'(HIGH_CYCLES - 1);
    localparam logic [CNT_W-1:0]  GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [PEND_W-1:0] PEND_MAX  = PEND_W'(MAX_PENDING);
    localparam bit                RETRIG    = (RETRIGGER != 0);

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [PEND_W-1:0] pend, pend_nxt;
    logic              drop_nxt;
    logic              out_nxt;
    logic              busy_nxt;
    logic              full;

    assign full    = (pend == PEND_MAX);
    assign pending = pend;

    // Next-state, counter and queue update; outputs are derived from the
    // next state so they can be registered alongside it.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        pend_nxt  = pend;
        drop_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (in) begin
                    state_nxt = HIGH;
                    cnt_nxt   = HIGH_LOAD;
                end
            end
            HIGH: begin
                if (in && RETRIG) begin
                    // merge into current pulse, including on its last cycle
                    cnt_nxt = HIGH_LOAD;
                end else begin
                    if (in) begin
                        if (full) drop_nxt = 1'b1;
                        else      pend_nxt = pend + PEND_W'(1);
                    end
                    if (cnt == '0) begin
                        state_nxt = GAP;
                        cnt_nxt   = GAP_LOAD;
                    end else begin
                        cnt_nxt = cnt - CNT_W'(1);
                    end
                end
            end
            GAP: begin
                if (cnt == '0) begin
                    if (in) begin
                        // arriving event is replayed directly: the queue is
                        // untouched, so a full queue does not drop it
                        state_nxt = HIGH;
                        cnt_nxt   = HIGH_LOAD;
                    end else if (pend != '0) begin
                        state_nxt = HIGH;
                        cnt_nxt   = HIGH_LOAD;
                        pend_nxt  = pend - PEND_W'(1);
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                    if (in) begin
                        if (full) drop_nxt = 1'b1;
                        else      pend_nxt = pend + PEND_W'(1);
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
        out_nxt  = (state_nxt == HIGH);
        busy_nxt = (state_nxt != IDLE);
    end

    // State, counters and registered outputs; reset clears everything at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            pend    <= '0;
            out     <= 1'b0;
            busy    <= 1'b0;
            dropped <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            pend    <= pend_nxt;
            out     <= out_nxt;
            busy    <= busy_nxt;
            dropped <= drop_nxt;
        end
    end

endmodule

// File: tb/tb_pulse_stretch.sv
// Scoreboard bench for pulse_stretch. Stimulus drives per-cycle directed
// vectors and queues the hand-computed outputs; a monitor pops and checks.
// Instance a uses defaults, instance b uses RETRIGGER=1.
module tb_pulse_stretch;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_a, in_b;
    logic       out_a, busy_a, drop_a;
    logic       out_b, busy_b, drop_b;
    logic [1:0] pend_a, pend_b;

    typedef struct {
        bit         sel;
        logic [4:0] v;     // {out, busy, pending[1:0], dropped}
        string      nm;
        int         cyc;
    } exp_t;

    exp_t q[$];
    event mon_ev;
    int   n_cmp = 0;
    int   n_err = 0;

    pulse_stretch u_a (
        .clk(clk), .reset(reset), .in(in_a),
        .out(out_a), .busy(busy_a), .pending(pend_a), .dropped(drop_a)
    );

    pulse_stretch #(.RETRIGGER(1)) u_b (
        .clk(clk), .reset(reset), .in(in_b),
        .out(out_b), .busy(busy_b), .pending(pend_b), .dropped(drop_b)
    );

    always #5 clk = ~clk;

    // Monitor: compares on every falling edge, or on demand for async checks.
    initial begin
        forever begin
            @(negedge clk or mon_ev);
            if (q.size() > 0) begin
                exp_t       e;
                logic [4:0] act;
                e   = q.pop_front();
                act = e.sel ? {out_b, busy_b, pend_b, drop_b}
                            : {out_a, busy_a, pend_a, drop_a};
                n_cmp++;
                if (act !== e.v) begin
                    n_err++;
                    $display("FAIL %s cycle %0d: out/busy/pend/drop got %b/%b/%0d/%b want %b/%b/%0d/%b",
                             e.nm, e.cyc, act[4], act[3], act[2:1], act[0],
                             e.v[4], e.v[3], e.v[2:1], e.v[0]);
                end
            end
        end
    end

    task automatic push(input bit sel, input logic [4:0] v, input string nm, input int c);
        exp_t e;
        e.sel = sel; e.v = v; e.nm = nm; e.cyc = c;
        q.push_back(e);
    endtask

    // rs: '1' = reset held low this cycle, 'm' = reset asserted mid-cycle
    // (after the normal check) with an immediate all-zero check.
    task automatic run(input bit sel, input string nm, input string rs,
                       input string ins, input string os, input string bs,
                       input string ps, input string ds);
        for (int c = 0; c < ins.len(); c++) begin
            @(posedge clk);
            #1;
            reset = !((rs.len() > c) && (rs[c] == "1"));
            if (sel) in_b = (ins[c] == "1");
            else     in_a = (ins[c] == "1");
            push(sel, {os[c] == "1", bs[c] == "1", 2'(ps[c] - 8'd48), ds[c] == "1"}, nm, c);
            if ((rs.len() > c) && (rs[c] == "m")) begin
                @(negedge clk);
                #1;
                reset = 1'b0;
                #1;
                push(sel, 5'b0, {nm, "_async"}, c);
                ->mon_ev;
            end
        end
        in_a = 1'b0;
        in_b = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        in_a  = 1'b0;
        in_b  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        push(0, 5'b0, "reset_a", 0);
        ->mon_ev;
        #1;
        push(1, 5'b0, "reset_b", 0);
        ->mon_ev;
        #1;
        reset = 1'b1;

        run(0, "single", "",
            "100000000",
            "011110000",
            "011111100",
            "000000000",
            "000000000");

        run(0, "queued", "",
            "101100000000000000000",
            "011110011110011110000",
            "011111111111111111100",
            "000122211111100000000",
            "000000000000000000000");

        run(0, "overflow", "",
            "111111000000000000000000000",
            "011110011110011110011110000",
            "011111111111111111111111100",
            "001233322222211111100000000",
            "000001100000000000000000000");

        run(1, "retrigger", "",
            "100100000000",
            "011111110000",
            "011111111100",
            "000000000000",
            "000000000000");

        run(0, "final_gap", "",
            "1000001000000000",
            "0111100111100000",
            "0111111111111000",
            "0000000000000000",
            "0000000000000000");

        run(0, "final_gap_full", "",
            "111100100000000000000000000000000",
            "011110011110011110011110011110000",
            "011111111111111111111111111111100",
            "001233333333322222211111100000000",
            "000000000000000000000000000000000");

        run(0, "reset_mid", "000m10000000000",
            "111000100000000",
            "011100011110000",
            "011100011111100",
            "001200000000000",
            "000000000000000");

        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expected vectors left unchecked, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation still running at %0t, want finished", $time);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pulse_stretch.md
# pulse_stretch

Converts single-cycle event pulses into fixed-width output pulses with a guaranteed low gap between them. A typical input is a button edge or a decoder command strobe; a typical output drives an LED, a buzzer gate or a slow peripheral strobe. Events that arrive while an output pulse is in progress are either merged into the current pulse (retrigger mode) or queued in a small saturating counter and replayed in order, so slow consumers never miss an event.

## Interface
Parameters:
- HIGH_CYCLES, 4: width of each output pulse in clk cycles. Must be 1 or more.
- GAP_CYCLES, 2: minimum low time after each output pulse. Must be 1 or more.
- RETRIGGER, 0: controls events that arrive during HIGH. 1 reloads the width counter. 0 queues the event.
- MAX_PENDING, 3: saturation value of the queued-event counter. Must be 1 or more.
- CNT_W, 8: width of the cycle counter. Must satisfy 2^CNT_W >= max(HIGH_CYCLES, GAP_CYCLES).
- PEND_W, 2: width of the pending counter. Must satisfy 2^PEND_W > MAX_PENDING.

Ports:
- clk  in  1  system clock. All state is updated on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- in  in  1  event input. Every cycle in which it is sampled high counts as one event.
- out  out  1  stretched pulse output, registered.
- busy  out  1  high while the block is in HIGH or GAP, registered.
- pending  out  PEND_W  number of queued events not yet replayed.
- dropped  out  1  one-cycle flag: an event was discarded because the queue was full.

## Operation
- Three states: IDLE, HIGH, GAP. There is one down-counter `cnt` of width CNT_W and one counter `pend` of width PEND_W.
- IDLE:
  - out=0, busy=0.
  - When in=1: go to HIGH and load cnt=HIGH_CYCLES-1.
- HIGH:
  - out=1, busy=1.
  - When in=1 and RETRIGGER=1: reload cnt=HIGH_CYCLES-1 and stay in HIGH. This also applies on the final HIGH cycle.
  - When in=1 and RETRIGGER=0: pend+1. If pend==MAX_PENDING, pend is unchanged and dropped=1.
  - When cnt==0 and there is no reload: go to GAP and load cnt=GAP_CYCLES-1.
  - Otherwise decrement cnt.
- GAP:
  - out=0, busy=1.
  - When in=1: the event is queued as in HIGH with RETRIGGER=0. This applies in both RETRIGGER modes.
  - When cnt==0: if the effective pend is nonzero, go to HIGH, load cnt=HIGH_CYCLES-1, and decrement pend. Otherwise go to IDLE.
  - Effective pend is the stored pend plus any event arriving this cycle.
- Simultaneous enqueue and dequeue on the final GAP cycle: the arriving event is consumed directly.
  - pend is unchanged.
  - dropped=0, even when pend==MAX_PENDING.
- pend never wraps and never goes below 0.
- Reset asserted at any time, including mid-pulse:
  - state=IDLE, cnt=0, pend=0.
  - out=0, busy=0, dropped=0.
  - These take effect immediately, without waiting for a clock edge.
- The first rising clk edge after reset is released samples in normally.

## Timing
- Latency: when in is sampled high at edge N while in IDLE, out is high from edge N+1.
- Pulse width without retrigger: out is high for exactly HIGH_CYCLES cycles.
- Gap: out is low for at least GAP_CYCLES cycles between consecutive pulses.
- Replayed pulses follow back-to-back with no extra IDLE cycle between GAP and the next HIGH.
- busy rises in the same cycle as out. busy falls one cycle after the final GAP cycle.
- dropped is asserted in the cycle after the offending in sample and lasts one cycle.
- pending reflects the registered pend value.
- All outputs are registered. There is no combinational path from in to any output.
- Reset values: out=0, busy=0, pending=0, dropped=0.

## Test plan
All scenarios use the default parameters (HIGH_CYCLES=4, GAP_CYCLES=2, RETRIGGER=0, MAX_PENDING=3) unless a parameter is named.
- **Single event:** single in pulse at cycle 0.
  - out=1 in cycles 1–4, out=0 in cycles 5–6.
  - busy=1 in cycles 1–6, and 0 from cycle 7.
  - pending=0 throughout.
- **Queued events:** in pulses at cycles 0, 2 and 3.
  - pending reads 1, then 2.
  - Output pulses occupy cycles 1–4, 7–10 and 13–16.
  - busy falls at cycle 19.
  - dropped never asserts.
- **Queue overflow:** in held high for cycles 0–5.
  - The queue fills during cycles 1–3 and pending saturates at 3.
  - dropped=1 in cycles 5 and 6, one cycle after each of the events at cycles 4 and 5.
  - Exactly 4 output pulses are produced.
- **Retrigger:** RETRIGGER=1, in pulses at cycles 0 and 3.
  - out=1 continuously in cycles 1–7.
  - GAP in cycles 8–9, then IDLE.
  - pending stays 0.
- **Event on final GAP cycle:** in pulse at cycle 0 and another at cycle 6, the final GAP cycle.
  - The second pulse starts at cycle 7.
  - pending stays 0 and there is no IDLE cycle in between.
  - Repeat with pend=3 already queued: pending stays 3 and dropped=0.
- **Reset mid-operation:** assert reset at cycle 2 of a pulse while pend=2.
  - out, busy and pending clear at once, without waiting for a clock edge.
  - After reset is released, a new in pulse gives a clean 4-cycle out pulse.
